// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter sharing one UART transmit byte stream.
// Optional requester-ID prefix byte per grant: UART_ARB_ID_PREFIX_EN.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int MAX_PKT = 64
`ifdef UART_ARB_ID_PREFIX_EN
    ,
    parameter logic [7:0] ID_BASE = 8'h30
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ*8-1:0]        req_data,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     trunc
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAX_PKT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT);

`ifdef UART_ARB_ID_PREFIX_EN
    typedef enum logic [1:0] {ARB, XFER, PREFIX} state_t;
`else
    typedef enum logic [1:0] {ARB, XFER} state_t;
`endif

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_grant;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_inc;
    logic [IDW-1:0]  pick;
    logic [IDW-1:0]  cand;
    logic            found;
    logic            xfer_beat;
    int              idx;

    assign count_inc = count + CW'(1);

    // Rotating priority search starting just after the previous owner.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx  = (int'(last_grant) + i) % NREQ;
            cand = IDW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        out_data  = 8'h00;
        req_ready = '0;
        xfer_beat = 1'b0;
        case (state_q)
            ARB: begin
                if (found) begin
`ifdef UART_ARB_ID_PREFIX_EN
                    state_d = PREFIX;
`else
                    state_d = XFER;
`endif
                end
            end
`ifdef UART_ARB_ID_PREFIX_EN
            PREFIX: begin
                out_valid = 1'b1;
                out_data  = ID_BASE + 8'(grant_id);
                if (out_ready) state_d = XFER;
            end
`endif
            XFER: begin
                out_valid           = req_valid[grant_id];
                out_data            = req_data[8*grant_id +: 8];
                req_ready[grant_id] = out_ready;
                xfer_beat           = req_valid[grant_id] && out_ready;
                if (xfer_beat && (req_last[grant_id] || count_inc == MAX_CNT))
                    state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            busy       <= 1'b0;
            grant_id   <= '0;
            trunc      <= 1'b0;
            count      <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            trunc   <= 1'b0;
            if (state_q == ARB && found) begin
                grant_id <= pick;
                busy     <= 1'b1;
                count    <= '0;
            end
            if (xfer_beat) begin
                count <= count_inc;
                // A final byte on the MAX_PKT beat is a normal release, not a truncation.
                if (req_last[grant_id]) begin
                    busy       <= 1'b0;
                    last_grant <= grant_id;
                end else if (count_inc == MAX_CNT) begin
                    busy       <= 1'b0;
                    last_grant <= grant_id;
                    trunc      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter (NREQ=4, MAX_PKT=4).
module tb_uart_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int MAX_PKT = 4;
`ifdef UART_ARB_ID_PREFIX_EN
    localparam int PFX = 1;
`else
    localparam int PFX = 0;
`endif

    logic              clk;
    logic              rst;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        grant_id;
    logic              busy;
    logic              trunc;

    uart_tx_arbiter #(.NREQ(NREQ), .MAX_PKT(MAX_PKT)) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .grant_id(grant_id),
        .busy(busy), .trunc(trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0]  src_mem [NREQ][32];
    int          src_len [NREQ];
    int          src_pos [NREQ];
    logic [9:0]  exp_q[$];
    logic [9:0]  exp_e;
    int          n_tests, n_fail;
    int          acc_cnt, run_beats, trunc_cnt, a0, k;
    bit          or_toggle;
    logic [NREQ-1:0] s_ready;
    logic        s_valid, s_oready, s_busy, s_trunc, prev_stall;
    logic [7:0]  s_data, prev_data;
    logic [1:0]  s_gid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (src_pos[i] < src_len[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_mem[i][src_pos[i]][7:0];
                req_last[i]        = src_mem[i][src_pos[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic load(input int id, input int n, input logic [7:0] base,
                        input bit last_end, input bit expect_it);
        if (expect_it && PFX == 1) exp_q.push_back({2'(id), 8'h30 + 8'(id)});
        for (int j = 0; j < n; j++) begin
            src_mem[id][src_len[id]] = {(last_end && j == n - 1), base + 8'(j)};
            src_len[id]++;
            if (expect_it) exp_q.push_back({2'(id), base + 8'(j)});
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NREQ; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++)
            if (src_pos[i] < src_len[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Sample at negedge, score the beat, then advance sources after the edge.
    task automatic cycle();
        @(negedge clk);
        s_ready = req_ready; s_valid = out_valid; s_oready = out_ready;
        s_busy = busy; s_trunc = trunc; s_data = out_data; s_gid = grant_id;
        check("rdy_gate", 32'(s_ready & ~{NREQ{s_oready}}), 0);
        check("onehot", 32'($countones(s_ready) <= 1), 1);
        if (prev_stall) check("stall_hold", {s_valid, s_data}, {1'b1, prev_data});
        prev_stall = s_valid && !s_oready;
        prev_data  = s_data;
        if (s_trunc) begin
            trunc_cnt++;
            check("trunc_at", run_beats, MAX_PKT + PFX);
        end
        if (!s_busy) run_beats = 0;
        if (s_valid && s_oready) begin
            acc_cnt++;
            run_beats++;
            if (exp_q.size() == 0) check("unexpected_beat", {s_gid, s_data}, 32'hFFFF);
            else begin
                exp_e = exp_q.pop_front();
                check("beat", {s_gid, s_data}, exp_e);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (s_ready[i] && req_valid[i]) src_pos[i]++;
        out_ready = or_toggle ? ~out_ready : 1'b1;
        drive();
    endtask

    task automatic run_idle(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || pending() || s_busy) && c < budget) begin
            cycle();
            c++;
        end
        check("idle_budget", 32'(c < budget), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_src();
        drive();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; acc_cnt = 0; run_beats = 0; trunc_cnt = 0;
        or_toggle = 0; prev_stall = 0; prev_data = 0; s_busy = 0;
        out_ready = 1'b1;
        clear_src();
        req_data = '0; req_valid = '0; req_last = '0;
        rst = 1'b1;
        drive();
        cycle();
        cycle();
        check("rst_busy", s_busy, 0);
        check("rst_valid", s_valid, 0);
        check("rst_ready", s_ready, 0);
        check("rst_data", s_data, 0);
        check("rst_trunc", s_trunc, 0);
        check("rst_gid", s_gid, 0);
        rst = 1'b0;

        // Single requester: latency and busy drop
        load(0, 2, 8'h41, 1, 1);
        drive();
        cycle();
        check("t1_lat0", s_valid, 0);
        cycle();
        check("t1_lat1", s_valid, 1);
        check("t1_first", s_data, (PFX == 1) ? 8'h30 : 8'h41);
`ifndef UART_ARB_ID_PREFIX_EN
        cycle();
        check("t1_second", {s_valid, s_data}, {1'b1, 8'h42});
        cycle();
        check("t1_busy", s_busy, 0);
`endif
        run_idle(50);

        // Contention: 0,2,3 then round-robin 0,2,0
        do_reset();
        load(0, 3, 8'h10, 1, 1);
        load(2, 3, 8'h20, 1, 1);
        load(3, 3, 8'h30, 1, 1);
        drive();
        run_idle(100);
        load(0, 3, 8'h50, 1, 1);
        load(2, 3, 8'h60, 1, 1);
        load(0, 3, 8'h70, 1, 1);
        drive();
        run_idle(100);

        // Backpressure with out_ready toggling
        a0 = acc_cnt;
        or_toggle = 1;
        load(1, 3, 8'h80, 1, 1);
        drive();
        run_idle(100);
        or_toggle = 0;
        out_ready = 1'b1;
        check("t3_cnt", acc_cnt - a0, 3 + PFX);

        // Truncation at MAX_PKT, grant moves on
        do_reset();
        trunc_cnt = 0;
        load(1, 4, 8'hA0, 0, 1);
        load(2, 1, 8'hB0, 1, 1);
        load(1, 2, 8'hA4, 1, 1);
        drive();
        run_idle(100);
        check("t4_trunc_cnt", trunc_cnt, 1);

        // Reset mid-packet
        do_reset();
        a0 = acc_cnt;
        load(0, 2, 8'hC0, 0, 1);
        load(0, 3, 8'hC2, 1, 0);
        drive();
        k = 0;
        while (acc_cnt - a0 < 2 + PFX && k < 50) begin
            cycle();
            k++;
        end
        check("t5_budget", 32'(k < 50), 1);
        rst = 1'b1;
        clear_src();
        drive();
        cycle();
        rst = 1'b0;
        load(0, 1, 8'hD0, 1, 1);
        load(3, 1, 8'hD3, 1, 1);
        drive();
        cycle();
        check("t5_valid", s_valid, 0);
        check("t5_busy", s_busy, 0);
        run_idle(50);

        // Single-byte packet (prefixed when the ID prefix is enabled)
        load(2, 1, 8'h55, 1, 1);
        drive();
        run_idle(50);

        check("drain", exp_q.size(), 0);
        check("trunc_total", trunc_cnt, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
